// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port main memory: registered ownership,
// per-owner lock for atomic sequences, and a bounded-wait forced handoff.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t            owner;
    owner_t            owner_nxt;
    owner_t            last_owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_hit;
    logic              other_req;

    assign wait_hit  = (wait_cnt >= CNT_W'(MAX_WAIT - 1));
    assign other_req = ((owner == OWN_M0) && req1) || ((owner == OWN_M1) && req0);

    // Lock only holds the bus while the owner keeps requesting; an
    // unlocked owner yields once the other side has waited long enough.
    always_comb begin
        owner_nxt = owner;
        unique case (owner)
            OWN_NONE: begin
                if (req0 && req1)
                    owner_nxt = (last_owner == OWN_M1) ? OWN_M0 : OWN_M1;
                else if (req0)
                    owner_nxt = OWN_M0;
                else if (req1)
                    owner_nxt = OWN_M1;
                else
                    owner_nxt = OWN_NONE;
            end
            OWN_M0: begin
                if (req0) begin
                    if (!lock0 && req1 && wait_hit)
                        owner_nxt = OWN_M1;
                end else begin
                    owner_nxt = req1 ? OWN_M1 : OWN_NONE;
                end
            end
            OWN_M1: begin
                if (req1) begin
                    if (!lock1 && req0 && wait_hit)
                        owner_nxt = OWN_M0;
                end else begin
                    owner_nxt = req0 ? OWN_M0 : OWN_NONE;
                end
            end
            default: owner_nxt = OWN_NONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_NONE;
            last_owner <= OWN_M1;
            wait_cnt   <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            owner <= owner_nxt;
            gnt0  <= (owner_nxt == OWN_M0);
            gnt1  <= (owner_nxt == OWN_M1);
            busy  <= (owner_nxt != OWN_NONE);
            if (owner_nxt != OWN_NONE)
                last_owner <= owner_nxt;
            if ((owner_nxt != owner) || !other_req)
                wait_cnt <= '0;
            else if (wait_cnt != {CNT_W{1'b1}})
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Non-owner inputs never reach the memory port; reset forces it quiet
    // so an in-flight write cannot commit.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (reset) begin
            unique case (owner)
                OWN_M0: begin
                    mem_addr  = addr0;
                    mem_we    = we0 && req0;
                    mem_wdata = wdata0;
                end
                OWN_M1: begin
                    mem_addr  = addr1;
                    mem_we    = we1 && req1;
                    mem_wdata = wdata1;
                end
                default: begin
                    mem_addr  = '0;
                    mem_we    = 1'b0;
                    mem_wdata = '0;
                end
            endcase
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a behavioural ownership/memory model
// queues expected outputs per cycle, a negedge monitor compares them.
module tb_mem_bus_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic [1:0]     req, lock, we;
    logic [AW-1:0]  addr [2];
    logic [DW-1:0]  wdata [2];
    logic           gnt0, gnt1, busy, mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  rdata, mem_wdata, mem_rdata;

    logic [7:0] mem       [0:65535];
    logic [7:0] model_mem [0:65535];

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .req0(req[0]), .lock0(lock[0]), .addr0(addr[0]), .we0(we[0]), .wdata0(wdata[0]), .gnt0(gnt0),
        .req1(req[1]), .lock1(lock[1]), .addr1(addr[1]), .we1(we[1]), .wdata1(wdata[1]), .gnt1(gnt1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct packed {
        logic        gnt0, gnt1, busy, we;
        logic [15:0] addr;
        logic [7:0]  wdata, rdata;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int own, last, waiting;   // own/last: -1 none, 0 CPU, 1 DMA

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference: commit the owner's write, then choose
    // who holds the bus next from the request/lock/wait rules.
    function automatic void model_step();
        int nxt;
        int y;
        if (own >= 0) begin
            if (req[own] && we[own]) model_mem[addr[own]] = wdata[own];
        end
        if (own < 0) begin
            if (req == 2'b11)  nxt = 1 - last;
            else if (req[0])   nxt = 0;
            else if (req[1])   nxt = 1;
            else               nxt = -1;
        end else begin
            y = 1 - own;
            if (!req[own])                                            nxt = req[y] ? y : -1;
            else if (!lock[own] && req[y] && waiting + 1 >= MAX_WAIT) nxt = y;
            else                                                      nxt = own;
        end
        if (own >= 0 && nxt == own) begin
            if (req[1 - own]) waiting = waiting + 1;
            else              waiting = 0;
        end else begin
            waiting = 0;
        end
        if (nxt >= 0) last = nxt;
        own = nxt;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        if (own >= 0) begin
            e.gnt0  = (own == 0);
            e.gnt1  = (own == 1);
            e.busy  = 1'b1;
            e.addr  = addr[own];
            e.we    = req[own] && we[own];
            e.wdata = wdata[own];
        end
        e.rdata = model_mem[e.addr];
        return e;
    endfunction

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clock);
        if (reset) model_step();
        #1;
        req = r; lock = l; we = w;
        addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
        if (reset) exp_q.push_back(expect_now());
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt0",      gnt0,      e.gnt0);
            chk("gnt1",      gnt1,      e.gnt1);
            chk("busy",      busy,      e.busy);
            chk("mem_we",    mem_we,    e.we);
            chk("mem_addr",  mem_addr,  e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("rdata",     rdata,     e.rdata);
        end
    end

    initial begin
        logic [7:0]  v;
        logic [7:0]  orig0, orig_rst;
        logic [1:0]  r, l, w;
        logic [15:0] pool [4];
        pool[0] = 16'h0000; pool[1] = 16'h0200; pool[2] = 16'hF020; pool[3] = 16'h1234;

        own = -1; last = 1; waiting = 0;
        reset = 1'b1;
        req = '0; lock = '0; we = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            model_mem[i] = v;
        end
        orig0 = model_mem[0];

        #2 reset = 1'b0;
        #1;
        chk("rst_gnt0",   gnt0,     1'b0);
        chk("rst_gnt1",   gnt1,     1'b0);
        chk("rst_busy",   busy,     1'b0);
        chk("rst_mem_we", mem_we,   1'b0);
        chk("rst_addr",   mem_addr, 16'h0000);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;

        // Simultaneous requests from idle: CPU first, drop CPU, then tie again
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        #3 chk("tie_gnt0", gnt0, 1'b1);
        chk("tie_gnt1", gnt1, 1'b0);
        drive(2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        #3 chk("drop_gnt1", gnt1, 1'b1);
        drive(2'b00, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        #3 chk("retie_gnt0", gnt0, 1'b1);

        // Bounded wait: DMA gets the bus on the 4th edge after it requests
        drive(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
            #3 chk("starve_gnt1", gnt1, (k == 4));
        end
        chk("starve_gnt0", gnt0, 1'b0);

        // DMA lock holds the bus against a waiting CPU
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 2'b10, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
            #3 chk("lock_gnt1", gnt1, 1'b1);
        end
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        #3 chk("unlock_hold", gnt1, 1'b1);
        drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00);
        #3 chk("unlock_gnt0", gnt0, 1'b1);
        chk("unlock_gnt1", gnt1, 1'b0);

        // CPU read of 0x0200 from idle
        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        drive(2'b01, 2'b00, 2'b00, 16'h0200, 16'h0000, 8'h00, 8'h00);
        drive(2'b01, 2'b00, 2'b00, 16'h0200, 16'h0000, 8'h00, 8'h00);
        #3 chk("rd_gnt0", gnt0, 1'b1);
        chk("rd_addr",  mem_addr, 16'h0200);
        chk("rd_rdata", rdata,    model_mem[16'h0200]);

        // DMA write while the CPU drives a write it does not own
        drive(2'b10, 2'b00, 2'b11, 16'h0000, 16'hF020, 8'h55, 8'hC0);
        drive(2'b10, 2'b00, 2'b11, 16'h0000, 16'hF020, 8'h55, 8'hC0);
        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'hF020, 8'h55, 8'hC0);
        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        #3 chk("dma_wr", mem[16'hF020], 8'hC0);
        chk("dma_cpu_nowr", mem[16'h0000], orig0);

        // Reset dropped in the middle of a CPU write cycle
        drive(2'b01, 2'b00, 2'b01, 16'h1234, 16'h0000, 8'hA5, 8'h00);
        drive(2'b01, 2'b00, 2'b01, 16'h1234, 16'h0000, 8'hA5, 8'h00);
        orig_rst = model_mem[16'h1234];
        #6 reset = 1'b0;
        own = -1; last = 1; waiting = 0;
        #1;
        chk("mid_rst_gnt0",   gnt0,     1'b0);
        chk("mid_rst_mem_we", mem_we,   1'b0);
        chk("mid_rst_busy",   busy,     1'b0);
        chk("mid_rst_addr",   mem_addr, 16'h0000);
        @(posedge clock);
        #1 chk("mid_rst_nowr", mem[16'h1234], orig_rst);
        req = 2'b11; we = 2'b00;
        #2 reset = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 16'h1234, 16'h0040, 8'h00, 8'h00);
        #3 chk("post_rst_gnt0", gnt0, 1'b1);

        // Randomised traffic over a small address pool so reads see writes
        for (int i = 0; i < 1500; i++) begin
            r = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            l = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            w = {($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1)};
            drive(r, l, w, pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                  8'($urandom), 8'($urandom));
        end

        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        @(negedge clock);
        @(negedge clock);
        #1 chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single-port 64K main memory between two bus masters: master 0 is the CPU and master 1 is a DMA/loader engine. Ownership is registered. Each owner may hold the bus for an atomic multi-cycle sequence using a lock input. A bounded-wait rule prevents an unlocked master from starving the other. The block sits between the masters and the Memory block; memory read data is combinational and writes commit on the rising clock edge.

Parameters:
ADDR_W, 16, address width of both masters and the memory port
DATA_W, 8, data width
MAX_WAIT, 4, number of cycles a requesting non-owner waits behind an unlocked owner before forced handoff (minimum 1)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req0  input  1  master 0 (CPU) requests the bus
lock0  input  1  master 0 holds the bus across cycles
addr0  input  ADDR_W  master 0 address
we0  input  1  master 0 write enable
wdata0  input  DATA_W  master 0 write data
gnt0  output  1  master 0 owns the bus this cycle
req1, lock1, addr1, we1, wdata1, gnt1  as above for master 1 (DMA)
rdata  output  DATA_W  memory read data, broadcast to both masters
mem_addr  output  ADDR_W  memory address
mem_we  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  bus owned (gnt0 OR gnt1)

Behaviour:
- State: owner in {NONE, M0, M1}; last_owner in {M0, M1}; wait_cnt is clog2(MAX_WAIT)+1 bits wide and saturating.
- Reset values (on reset=0, immediate): owner=NONE, last_owner=M1 (so M0 wins the first tie), wait_cnt=0, gnt0=gnt1=0, busy=0.
- Outputs while reset is asserted: mem_addr=0, mem_we=0, mem_wdata=0.
- gnt0/gnt1 are decoded from the owner register. They are never both 1.
- Memory mux is combinational from owner:
  - owner M0: mem_addr=addr0, mem_wdata=wdata0, mem_we=we0 AND req0.
  - owner M1: same, using master 1 signals.
  - owner NONE: mem_addr=0, mem_we=0, mem_wdata=0.
- rdata = mem_rdata at all times. It is valid in the same cycle as the owner's address.
- Access rule: a master's access occurs only in a cycle where its gnt=1 and its req=1. A write commits at the rising edge that ends that cycle.
- Grant latency: a request raised while the owner is NONE gets gnt on the next rising edge. Handoff between masters also takes exactly one edge; there is no idle gap cycle.
- Next-owner logic, evaluated each edge:
  - NONE:
    - Only req0 → M0. Only req1 → M1.
    - Both → the master that is not last_owner.
    - Neither → NONE.
  - Owner Mx, other master My:
    - req_x=1 and lock_x=1 → stay Mx. Lock is absolute; wait_cnt keeps counting and saturates.
    - req_x=1, lock_x=0, req_y=1 and wait_cnt >= MAX_WAIT-1 → My (forced handoff).
    - req_x=1, lock_x=0, otherwise → stay Mx.
    - req_x=0 and req_y=1 → My.
    - req_x=0 and req_y=0 → NONE.
- last_owner updates to Mx on every edge where owner becomes or remains Mx.
- wait_cnt:
  - Increments on each edge where the non-owner requests and owner stays unchanged.
  - Clears to 0 on any owner change, or when no non-owner is requesting.
- Dropping req while locked releases the bus; lock without req is ignored.
- Reset mid-write: mem_we drops immediately with reset; no write commits on the next edge.
- Inputs of a non-granted master have no effect on the memory port.

Test Plan:
- Reset, then req0=1, addr0=16'h0200 → gnt0=1 after 1 edge; mem_addr=16'h0200; rdata equals memory cell 16'h0200.
- From idle, req0 and req1 raised in the same cycle → gnt0 first. Drop req0 → gnt1=1 on the next edge. Re-raise both from idle → gnt0 again, since last_owner=M1.
- M0 owns unlocked, req0 held, req1=1 with MAX_WAIT=4 → gnt1=1 exactly 4 edges after req1 is raised; gnt0=0 in the same cycle.
- M1 owns with lock1=1 for 10 cycles while req0=1 → gnt1 held all 10 cycles. Drop lock1 → gnt0=1 on the next edge, because wait_cnt is saturated.
- M1 writes 8'hC0 to 16'hF020 while master 0 drives we0=1, addr0=16'h0000 → only 16'hF020 is written; cell 16'h0000 is unchanged.
- Assert reset low mid-cycle while M0 has we0=1 → gnt0, mem_we and busy go to 0 immediately; the target cell is unchanged; after release the first grant goes to M0.
